// File: rtl/rr_select_generator.sv
// Round-robin grant generator feeding a std selector: picks the next requester
// after the last acknowledged grant and holds the grant until it is acknowledged.
package std_selector_pkg;

    typedef enum logic [1:0] {
        selector_kind_BINARY,
        selector_kind_ONEHOT,
        selector_kind_VECTOR
    } selector_kind;

    function automatic int calc_binary_select_width(input int entries);
        return (entries <= 1) ? 1 : $clog2(entries);
    endfunction

    function automatic int calc_select_width(input int entries, input selector_kind kind);
        return (kind == selector_kind_BINARY) ? calc_binary_select_width(entries) : entries;
    endfunction

endpackage

module rr_select_generator #(
    parameter int                            ENTRIES = 4,
    parameter std_selector_pkg::selector_kind KIND   = std_selector_pkg::selector_kind_BINARY,
    localparam int IW = std_selector_pkg::calc_binary_select_width(ENTRIES),
    localparam int SW = std_selector_pkg::calc_select_width(ENTRIES, KIND)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [ENTRIES-1:0] i_request,
    input  logic               i_ack,
    output logic               o_valid,
    output logic [SW-1:0]      o_select,
    output logic [IW-1:0]      o_index
);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      base;
    logic [IW-1:0]      win;
    logic [IW-1:0]      win_hi;
    logic [IW-1:0]      win_lo;
    logic [ENTRIES-1:0] mask_ge;
    logic [ENTRIES-1:0] req_hi;
    logic [SW-1:0]      sel_next;
    logic               any_req;
    logic               load_slot;
    logic               retire;

    assign any_req   = |i_request;
    assign load_slot = !o_valid || i_ack;
    assign retire    = o_valid && i_ack;

    // An acknowledged grant moves priority past the winner in the same edge,
    // so back-to-back grants see the rotated pointer without a bubble.
    always_comb begin
        base = ptr;
        if (retire) begin
            if (o_index == IW'(ENTRIES - 1))
                base = '0;
            else
                base = o_index + 1'b1;
        end
    end

    // Requests at or above base win first; otherwise the scan wraps to index 0.
    always_comb begin
        mask_ge = '0;
        for (int i = 0; i < ENTRIES; i++)
            mask_ge[i] = (IW'(i) >= base);
    end

    assign req_hi = i_request & mask_ge;

    always_comb begin
        win_hi = '0;
        win_lo = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (req_hi[i])
                win_hi = IW'(i);
            if (i_request[i])
                win_lo = IW'(i);
        end
    end

    assign win = (|req_hi) ? win_hi : win_lo;

    generate
        if (KIND == std_selector_pkg::selector_kind_BINARY) begin : g_bin
            assign sel_next = win;
        end else begin : g_onehot
            for (genvar g = 0; g < ENTRIES; g++) begin : g_bit
                assign sel_next[g] = (win == IW'(g));
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr      <= '0;
            o_valid  <= 1'b0;
            o_select <= '0;
            o_index  <= '0;
        end else if (load_slot) begin
            if (retire)
                ptr <= base;
            if (any_req) begin
                o_valid  <= 1'b1;
                o_select <= sel_next;
                o_index  <= win;
            end else begin
                o_valid  <= 1'b0;
                o_select <= '0;
                o_index  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_select_generator.sv
// Bench for rr_select_generator: three configurations checked every cycle
// against a modulo-arithmetic round-robin model, plus directed scenarios.
module tb_rr_select_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // ENTRIES=4 BINARY
    logic       rst4, ack4, v4;
    logic [3:0] req4;
    logic [1:0] sel4, idx4;
    // ENTRIES=5 ONEHOT
    logic       rst5, ack5, v5;
    logic [4:0] req5, sel5;
    logic [2:0] idx5;
    // ENTRIES=1 BINARY
    logic       rst1, ack1, v1;
    logic [0:0] req1, sel1, idx1;

    rr_select_generator #(.ENTRIES(4), .KIND(std_selector_pkg::selector_kind_BINARY)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_request(req4), .i_ack(ack4),
        .o_valid(v4), .o_select(sel4), .o_index(idx4));

    rr_select_generator #(.ENTRIES(5), .KIND(std_selector_pkg::selector_kind_ONEHOT)) dut5 (
        .i_clk(clk), .i_rst(rst5), .i_request(req5), .i_ack(ack5),
        .o_valid(v5), .o_select(sel5), .o_index(idx5));

    rr_select_generator #(.ENTRIES(1), .KIND(std_selector_pkg::selector_kind_BINARY)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_request(req1), .i_ack(ack1),
        .o_valid(v1), .o_select(sel1), .o_index(idx1));

    bit mv4, mv5, mv1;
    int mi4, mi5, mi1;
    int mp4, mp5, mp1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: grant is a held token; priority starts at ptr and wraps mod n.
    function automatic void model_step(input int n, input int req, input bit ack, input bit rst,
                                       inout bit v, inout int idx, inout int ptr);
        if (rst) begin
            v = 0; idx = 0; ptr = 0;
            return;
        end
        if (v && !ack)
            return;
        if (v && ack)
            ptr = (idx + 1) % n;
        if (req == 0) begin
            v = 0; idx = 0;
        end else begin
            for (int off = n - 1; off >= 0; off--) begin
                int k;
                k = (ptr + off) % n;
                if (((req >> k) & 1) == 1) idx = k;
            end
            v = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(4, int'(req4), ack4, rst4, mv4, mi4, mp4);
        model_step(5, int'(req5), ack5, rst5, mv5, mi5, mp5);
        model_step(1, int'(req1), ack1, rst1, mv1, mi1, mp1);
        @(negedge clk);
        chk("v4",   int'(v4),   int'(mv4));
        chk("idx4", int'(idx4), mi4);
        chk("sel4", int'(sel4), mv4 ? mi4 : 0);
        chk("v5",   int'(v5),   int'(mv5));
        chk("idx5", int'(idx5), mi5);
        chk("sel5", int'(sel5), mv5 ? (1 << mi5) : 0);
        chk("v1",   int'(v1),   int'(mv1));
        chk("idx1", int'(idx1), 0);
        chk("sel1", int'(sel1), 0);
    endtask

    task automatic reset4();
        rst4 = 1; req4 = '0; ack4 = 0;
        tick();
        rst4 = 0;
    endtask

    initial begin
        int rot[5];
        rot = '{0, 1, 2, 3, 0};
        rst4 = 1; rst5 = 1; rst1 = 1;
        req4 = '0; req5 = '0; req1 = '0;
        ack4 = 0; ack5 = 0; ack1 = 0;
        mv4 = 1; mv5 = 1; mv1 = 1; mi4 = 3; mi5 = 3; mi1 = 0; mp4 = 1; mp5 = 1; mp1 = 0;
        tick();
        chk("reset_v4", int'(v4), 0);
        chk("reset_v5", int'(v5), 0);
        rst4 = 0; rst5 = 0; rst1 = 0;

        // basic grant
        req4 = 4'b0100;
        tick();
        chk("basic_v", int'(v4), 1);
        chk("basic_idx", int'(idx4), 2);
        chk("basic_sel", int'(sel4), 2);

        // rotation with constant request and ack
        reset4();
        req4 = 4'b1111; ack4 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rot_v", int'(v4), 1);
            chk("rot_idx", int'(idx4), rot[i]);
        end

        // sticky grant
        reset4();
        req4 = 4'b0010;
        tick();
        req4 = 4'b1000;
        tick();
        tick();
        chk("sticky_hold", int'(idx4), 1);
        ack4 = 1;
        tick();
        chk("sticky_ack", int'(idx4), 3);
        req4 = '0;
        tick();
        ack4 = 0;

        // reset mid-grant
        reset4();
        req4 = 4'b1000;
        tick();
        chk("midrst_pre", int'(idx4), 3);
        rst4 = 1; req4 = 4'b1111;
        tick();
        chk("midrst_v", int'(v4), 0);
        rst4 = 0;
        tick();
        chk("midrst_idx", int'(idx4), 0);

        // spurious ack, then empty ack
        reset4();
        ack4 = 1;
        tick();
        tick();
        ack4 = 0; req4 = 4'b1111;
        tick();
        chk("spur_idx", int'(idx4), 0);
        req4 = '0; ack4 = 1;
        tick();
        chk("empty_v", int'(v4), 0);
        chk("empty_sel", int'(sel4), 0);
        ack4 = 0;

        // one-hot wrap on 5 entries
        req5 = 5'b10000;
        tick();
        chk("oh_sel", int'(sel5), 16);
        chk("oh_idx", int'(idx5), 4);
        ack5 = 1; req5 = 5'b00001;
        tick();
        chk("oh_wrap", int'(sel5), 1);
        ack5 = 0; req5 = '0;

        // single entry
        req1 = 1'b1;
        tick();
        chk("one_v", int'(v1), 1);
        req1 = 1'b0; ack1 = 1;
        tick();
        chk("one_clr", int'(v1), 0);

        // randomized traffic on all three instances
        for (int c = 0; c < 400; c++) begin
            req4 = 4'($urandom);
            req5 = 5'($urandom);
            req1 = 1'($urandom);
            ack4 = 1'($urandom);
            ack5 = 1'($urandom);
            ack1 = 1'($urandom);
            rst4 = ($urandom_range(0, 31) == 0);
            rst5 = ($urandom_range(0, 31) == 0);
            rst1 = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
